// File: rtl/trap_ctrl.sv
// Trap controller: samples pipeline state, arbitrates exception over interrupts, and presents one trap per valid/ready handshake.
// Latency: inputs sampled at edge N, o_trap_valid high after edge N+1; outputs hold in REQ until i_trap_ready.
module trap_ctrl #(
    parameter int XLEN    = 32,
    parameter int STAGES  = 6,
    parameter int NUM_INT = 16,
    parameter int HOLDOFF = 4
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_flush,
    input  logic                   i_mmu_wait,
    input  logic [STAGES*XLEN-1:0] i_stage_pc,
    input  logic                   i_exc_en,
    input  logic [3:0]             i_exc_code,
    input  logic                   i_chmode_do_in,
    input  logic [1:0]             i_chmode_to_in,
    input  logic                   i_int_allow,
    input  logic [NUM_INT-1:0]     i_int_pend,
    input  logic [1:0]             i_tvec_mode,
    input  logic [XLEN-1:0]        i_tvec_base,
    output logic                   o_trap_valid,
    input  logic                   i_trap_ready,
    output logic [XLEN-1:0]        o_trap_pc,
    output logic [XLEN-1:0]        o_trap_cause,
    output logic [XLEN-1:0]        o_trap_jmp_to,
    output logic                   o_chmode_do,
    output logic [1:0]             o_chmode_to,
    output logic                   o_int_masked
);
    localparam int CW = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_REQ  = 1'b1;

    logic [STAGES*XLEN-1:0] r_stage_pc;
    logic                   r_exc_en;
    logic [3:0]             r_exc_code;
    logic                   r_chmode_do;
    logic [1:0]             r_chmode_to;
    logic                   r_int_allow;
    logic [NUM_INT-1:0]     r_int_pend;
    logic [0:0]             r_state;
    logic [CW-1:0]          r_hold;
    logic [XLEN-1:0]        r_trap_pc;
    logic [XLEN-1:0]        r_trap_cause;
    logic [XLEN-1:0]        r_trap_jmp;

    logic            w_masked;
    logic            w_exc;
    logic            w_irq;
    logic [XLEN-1:0] w_pc;
    logic [3:0]      w_int_code;
    logic [3:0]      w_code;
    logic [XLEN-1:0] w_cause;
    logic [XLEN-1:0] w_base;
    logic [XLEN-1:0] w_jmp;
    logic            w_hs;

    assign w_masked = (r_hold != '0);
    assign w_exc    = r_exc_en;
    assign w_irq    = r_int_allow & (|r_int_pend) & ~w_masked;
    assign w_hs     = (r_state == S_REQ) & i_trap_ready;

    // Ascending scans so the highest-index hit is the one that sticks.
    always_comb begin
        w_pc       = '0;
        w_int_code = 4'd0;
        for (int i = 0; i < STAGES; i++) begin
            if (r_stage_pc[i*XLEN +: XLEN] != '0) w_pc = r_stage_pc[i*XLEN +: XLEN];
        end
        for (int i = 0; i < NUM_INT; i++) begin
            if (r_int_pend[i]) w_int_code = 4'(i);
        end
    end

    assign w_code = w_exc ? r_exc_code : w_int_code;
    assign w_base = i_tvec_base & ~XLEN'(3);

    always_comb begin
        w_cause            = '0;
        w_cause[3:0]       = w_code;
        w_cause[XLEN-1]    = ~w_exc;
    end

    assign w_jmp = (!w_exc && i_tvec_mode == 2'b01)
                 ? w_base + {{(XLEN-6){1'b0}}, w_code, 2'b00}
                 : w_base;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            r_stage_pc  <= '0;
            r_exc_en    <= 1'b0;
            r_exc_code  <= 4'd0;
            r_chmode_do <= 1'b0;
            r_chmode_to <= 2'd0;
            r_int_allow <= 1'b0;
            r_int_pend  <= '0;
        end else if (!i_mmu_wait) begin
            r_stage_pc  <= i_stage_pc;
            r_exc_en    <= i_exc_en;
            r_exc_code  <= i_exc_code;
            r_chmode_do <= i_chmode_do_in;
            r_chmode_to <= i_chmode_to_in;
            r_int_allow <= i_int_allow;
            r_int_pend  <= i_int_pend;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_hold <= '0;
        end else if (w_hs) begin
            r_hold <= CW'(HOLDOFF);
        end else if (r_hold != '0) begin
            r_hold <= r_hold - 1'b1;
        end
    end

    // FLUSH only clears the sampler; a condition already sampled still fires.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= S_IDLE;
            r_trap_pc    <= '0;
            r_trap_cause <= '0;
            r_trap_jmp   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if ((w_exc || w_irq) && !i_mmu_wait) begin
                        r_state      <= S_REQ;
                        r_trap_pc    <= w_pc;
                        r_trap_cause <= w_cause;
                        r_trap_jmp   <= w_jmp;
                    end
                end
                default: begin
                    if (i_trap_ready) r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_trap_valid  = (r_state == S_REQ);
    assign o_trap_pc     = r_trap_pc;
    assign o_trap_cause  = r_trap_cause;
    assign o_trap_jmp_to = r_trap_jmp;
    assign o_chmode_do   = r_chmode_do;
    assign o_chmode_to   = r_chmode_to;
    assign o_int_masked  = w_masked;
endmodule

// File: tb/tb_trap_ctrl.sv
// Directed test-plan steps followed by randomized cycles, all checked against a spec-level reference model.
module tb_trap_ctrl;
    localparam int XLEN = 32, STAGES = 6, NUM_INT = 16, HOLDOFF = 4;

    logic                   clk = 1'b0;
    logic                   rst, flush, mmu_wait, exc_en, chm_do_in, int_allow, ready;
    logic [3:0]             exc_code;
    logic [1:0]             chm_to_in, tvec_mode;
    logic [NUM_INT-1:0]     int_pend;
    logic [XLEN-1:0]        tvec_base;
    logic [STAGES*XLEN-1:0] stage_pc;
    logic [XLEN-1:0]        pcs [STAGES];
    logic                   trap_valid, chm_do, int_masked;
    logic [XLEN-1:0]        trap_pc, trap_cause, trap_jmp;
    logic [1:0]             chm_to;

    int checks = 0;
    int errors = 0;

    // Reference model state: the sampled inputs, the pending trap and the holdoff count.
    logic [XLEN-1:0]    s_pc [STAGES];
    logic               s_exc, s_allow, s_chm_do;
    logic [3:0]         s_code;
    logic [1:0]         s_chm_to;
    logic [NUM_INT-1:0] s_pend;
    logic               m_valid;
    logic [XLEN-1:0]    m_pc, m_cause, m_jmp;
    int                 m_hold;
    logic [XLEN-1:0]    held_pc, held_cause, held_jmp;

    trap_ctrl #(.XLEN(XLEN), .STAGES(STAGES), .NUM_INT(NUM_INT), .HOLDOFF(HOLDOFF)) dut (
        .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_mmu_wait(mmu_wait),
        .i_stage_pc(stage_pc), .i_exc_en(exc_en), .i_exc_code(exc_code),
        .i_chmode_do_in(chm_do_in), .i_chmode_to_in(chm_to_in),
        .i_int_allow(int_allow), .i_int_pend(int_pend),
        .i_tvec_mode(tvec_mode), .i_tvec_base(tvec_base),
        .o_trap_valid(trap_valid), .i_trap_ready(ready),
        .o_trap_pc(trap_pc), .o_trap_cause(trap_cause), .o_trap_jmp_to(trap_jmp),
        .o_chmode_do(chm_do), .o_chmode_to(chm_to), .o_int_masked(int_masked)
    );

    always #5 clk = ~clk;

    always_comb begin
        stage_pc = '0;
        for (int i = 0; i < STAGES; i++) stage_pc[i*XLEN +: XLEN] = pcs[i];
    end

    task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic clear_inputs();
        flush = 0; mmu_wait = 0; exc_en = 0; exc_code = 0; chm_do_in = 0; chm_to_in = 0;
        int_allow = 0; int_pend = 0; ready = 0;
        for (int i = 0; i < STAGES; i++) pcs[i] = '0;
    endtask

    // One clock: advance the model from pre-edge values, then compare after the edge.
    task automatic tick();
        logic            exc, irq, nv;
        logic [XLEN-1:0] npc, ncause, njmp;
        int              code, nh;
        exc  = s_exc;
        irq  = s_allow && (s_pend != 0) && (m_hold == 0);
        npc  = 0;
        for (int i = STAGES - 1; i >= 0; i--) if (npc == 0 && s_pc[i] != 0) npc = s_pc[i];
        code = 0;
        if (exc) code = int'(s_code);
        else for (int i = 0; i < NUM_INT; i++) if (s_pend[i]) code = i;
        ncause = exc ? XLEN'(code) : (XLEN'(1) << (XLEN - 1)) | XLEN'(code);
        njmp   = (tvec_base & ~XLEN'(3)) + ((!exc && tvec_mode == 2'b01) ? XLEN'(code * 4) : XLEN'(0));
        nv = m_valid;
        if (m_valid && ready) nv = 0;
        else if (!m_valid && (exc || irq) && !mmu_wait) nv = 1;
        nh = (m_valid && ready) ? HOLDOFF : (m_hold > 0 ? m_hold - 1 : 0);
        @(posedge clk);
        #1;
        if (rst) begin
            m_valid = 0; m_pc = 0; m_cause = 0; m_jmp = 0; m_hold = 0;
        end else begin
            if (!m_valid && nv) begin m_pc = npc; m_cause = ncause; m_jmp = njmp; end
            m_valid = nv; m_hold = nh;
        end
        if (rst || flush) begin
            for (int i = 0; i < STAGES; i++) s_pc[i] = 0;
            s_exc = 0; s_code = 0; s_allow = 0; s_pend = 0; s_chm_do = 0; s_chm_to = 0;
        end else if (!mmu_wait) begin
            for (int i = 0; i < STAGES; i++) s_pc[i] = pcs[i];
            s_exc = exc_en; s_code = exc_code; s_allow = int_allow; s_pend = int_pend;
            s_chm_do = chm_do_in; s_chm_to = chm_to_in;
        end
        chk("valid", XLEN'(trap_valid), XLEN'(m_valid));
        chk("masked", XLEN'(int_masked), XLEN'(m_hold != 0));
        chk("chmode_do", XLEN'(chm_do), XLEN'(s_chm_do));
        chk("chmode_to", XLEN'(chm_to), XLEN'(s_chm_to));
        if (m_valid || rst) begin
            chk("pc", trap_pc, m_pc);
            chk("cause", trap_cause, m_cause);
            chk("jmp", trap_jmp, m_jmp);
        end
    endtask

    task automatic handshake();
        ready = 1; tick(); ready = 0;
        chk("hs_valid_drop", XLEN'(trap_valid), 0);
    endtask

    initial begin
        m_valid = 0; m_pc = 0; m_cause = 0; m_jmp = 0; m_hold = 0;
        s_exc = 0; s_code = 0; s_allow = 0; s_pend = 0; s_chm_do = 0; s_chm_to = 0;
        for (int i = 0; i < STAGES; i++) s_pc[i] = 0;
        clear_inputs();
        tvec_mode = 2'b01; tvec_base = 32'h8000;
        rst = 1; tick(); tick();
        chk("rst_valid", XLEN'(trap_valid), 0);
        chk("rst_pc", trap_pc, 0);
        chk("rst_cause", trap_cause, 0);
        chk("rst_jmp", trap_jmp, 0);
        chk("rst_masked", XLEN'(int_masked), 0);
        rst = 0;

        // Exception into vectored mode still goes to base.
        exc_en = 1; exc_code = 2; pcs[5] = 32'h100; tick();
        clear_inputs();
        chk("exc_lat_n", XLEN'(trap_valid), 0);
        tick();
        chk("exc_valid", XLEN'(trap_valid), 1);
        chk("exc_pc", trap_pc, 32'h100);
        chk("exc_cause", trap_cause, 32'h2);
        chk("exc_jmp", trap_jmp, 32'h8000);
        handshake();
        repeat (5) tick();

        // Vectored interrupt, highest pending line 11.
        int_allow = 1; int_pend = 16'h0880; pcs[2] = 32'h40; tick();
        clear_inputs(); tick();
        chk("irq_cause", trap_cause, 32'h8000000B);
        chk("irq_jmp", trap_jmp, 32'h802C);
        chk("irq_pc", trap_pc, 32'h40);
        handshake();
        repeat (5) tick();

        // Exception and interrupt together, then holdoff on the interrupt.
        exc_en = 1; exc_code = 5; int_allow = 1; int_pend = 16'h0008; pcs[5] = 32'h200; tick();
        exc_en = 0; tick();
        chk("sim_cause", trap_cause, 32'h5);
        handshake();
        for (int k = 0; k < 3; k++) begin tick(); chk("holdoff_masked", XLEN'(int_masked), 1); end
        tick(); chk("holdoff_end", XLEN'(int_masked), 0);
        chk("holdoff_novalid", XLEN'(trap_valid), 0);
        tick(); chk("holdoff_irq_valid", XLEN'(trap_valid), 1);
        chk("holdoff_irq_cause", trap_cause, 32'h80000003);
        clear_inputs(); handshake();
        repeat (5) tick();

        // Stall and backpressure with a FLUSH pulse during REQ.
        exc_en = 1; exc_code = 7; pcs[4] = 32'h300; tick();
        clear_inputs(); mmu_wait = 1;
        for (int k = 0; k < 3; k++) begin tick(); chk("stall_novalid", XLEN'(trap_valid), 0); end
        mmu_wait = 0; tick();
        chk("stall_release", XLEN'(trap_valid), 1);
        held_pc = trap_pc; held_cause = trap_cause; held_jmp = trap_jmp;
        for (int k = 0; k < 5; k++) begin
            flush = (k == 2); mmu_wait = (k == 3);
            tick();
            chk("bp_pc", trap_pc, held_pc);
            chk("bp_cause", trap_cause, held_cause);
            chk("bp_jmp", trap_jmp, held_jmp);
        end
        clear_inputs(); handshake();

        // Reset while a request is outstanding.
        repeat (5) tick();
        exc_en = 1; exc_code = 3; pcs[0] = 32'h44; tick();
        clear_inputs(); tick();
        rst = 1; tick(); rst = 0;
        chk("rstreq_valid", XLEN'(trap_valid), 0);
        chk("rstreq_pc", trap_pc, 0);
        chk("rstreq_masked", XLEN'(int_masked), 0);

        // Target address wrap with a misaligned base.
        tvec_base = 32'hFFFFFFF3; int_allow = 1; int_pend = 16'h8000; tick();
        clear_inputs(); tick();
        chk("wrap_jmp", trap_jmp, 32'h0000002C);
        chk("wrap_cause", trap_cause, 32'h8000000F);
        handshake();

        for (int n = 0; n < 600; n++) begin
            rst       = ($urandom_range(0, 49) == 0);
            flush     = ($urandom_range(0, 9) == 0);
            mmu_wait  = ($urandom_range(0, 4) == 0);
            ready     = $urandom_range(0, 1) == 1;
            exc_en    = ($urandom_range(0, 7) == 0);
            exc_code  = 4'($urandom);
            chm_do_in = 1'($urandom);
            chm_to_in = 2'($urandom);
            int_allow = ($urandom_range(0, 3) != 0);
            int_pend  = ($urandom_range(0, 3) == 0) ? NUM_INT'($urandom) : '0;
            tvec_mode = 2'($urandom);
            tvec_base = $urandom;
            for (int i = 0; i < STAGES; i++) pcs[i] = $urandom_range(0, 1) ? $urandom : 32'h0;
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
